// File: rtl/debounce_pkg.sv
// ---------------------------------------------------------------------------
// debounce_pkg
// Shared types and constants for the multi-channel push-button conditioner.
//   db_state_t  : per-channel debounce FSM state
//   SYNC_STAGES : depth of the input synchroniser
//   maxInt      : elaboration-time helper used to size the shared counters
// ---------------------------------------------------------------------------
package debounce_pkg;

   typedef enum logic [1:0] {
      RELEASED    = 2'd0,
      PRESS_CHK   = 2'd1,
      HELD        = 2'd2,
      RELEASE_CHK = 2'd3
   } db_state_t;

   localparam int SYNC_STAGES = 2;

   function automatic int maxInt(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// ---------------------------------------------------------------------------
// debounce_channel
// One push-button lane: synchroniser, stable-count debouncer, optional
// auto-repeat and the sticky pending/overrun event flags.
// Ports:
//   clock            : single clock, posedge
//   reset            : synchronous, active-high
//   buttonNotPressed : raw asynchronous button, 0 = pressed
//   acknowledge      : clears pending and overrun (level-sampled)
//   debounce         : debounced pressed level, 1 = pressed
//   press_pulse      : one-cycle strobe per press or repeat
//   pending          : sticky event flag
//   overrun          : sticky flag, event arrived while pending was set
// ---------------------------------------------------------------------------
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int STABLE_CYCLES = 50000,
   parameter int REPEAT_CYCLES = 0,
   parameter int CNT_W         = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic buttonNotPressed,
   input  logic acknowledge,
   output logic debounce,
   output logic press_pulse,
   output logic pending,
   output logic overrun
);

   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam int               REP_LAST_I  = (REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0;
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REP_LAST_I);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   logic [SYNC_STAGES-1:0] syncFf;
   logic                   sync;
   db_state_t              state;
   db_state_t              stateNext;
   logic [CNT_W-1:0]       cnt;
   logic [CNT_W-1:0]       cntNext;
   logic [CNT_W-1:0]       rcnt;
   logic [CNT_W-1:0]       rcntNext;
   logic                   pressHit;
   logic                   releaseHit;
   logic                   repeatTick;
   logic                   eventHit;

   // Synchroniser stores the inverted (active-high) button so that reset
   // leaves it at the released value without any extra inversion later.
   always_ff @(posedge clock) begin
      if (reset) begin
         syncFf <= '0;
      end else begin
         syncFf <= {syncFf[SYNC_STAGES-2:0], ~buttonNotPressed};
      end
   end

   assign sync = syncFf[SYNC_STAGES-1];

   // State register together with the stability and repeat counters.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= RELEASED;
         cnt   <= '0;
         rcnt  <= '0;
      end else begin
         state <= stateNext;
         cnt   <= cntNext;
         rcnt  <= rcntNext;
      end
   end

   // Next-state logic: a check state counts consecutive cycles that the
   // synchronised input disagrees with the debounced level, and any agreement
   // drops back to the stable state. Every transition clears the counter.
   always_comb begin
      stateNext  = state;
      cntNext    = cnt;
      pressHit   = 1'b0;
      releaseHit = 1'b0;
      case (state)
         RELEASED: begin
            if (sync) begin
               stateNext = PRESS_CHK;
               cntNext   = CNT_ONE;
            end
         end
         PRESS_CHK: begin
            if (!sync) begin
               stateNext = RELEASED;
               cntNext   = '0;
            end else if (cnt == STABLE_LAST) begin
               stateNext = HELD;
               cntNext   = '0;
               pressHit  = 1'b1;
            end else begin
               cntNext = cnt + CNT_ONE;
            end
         end
         HELD: begin
            if (!sync) begin
               stateNext = RELEASE_CHK;
               cntNext   = CNT_ONE;
            end
         end
         RELEASE_CHK: begin
            if (sync) begin
               stateNext = HELD;
               cntNext   = '0;
            end else if (cnt == STABLE_LAST) begin
               stateNext  = RELEASED;
               cntNext    = '0;
               releaseHit = 1'b1;
            end else begin
               cntNext = cnt + CNT_ONE;
            end
         end
         default: begin
            stateNext = RELEASED;
            cntNext   = '0;
         end
      endcase
   end

   // Auto-repeat runs while the debounced level is high. The edge that
   // completes a release never ticks, so releasing yields no event.
   always_comb begin
      repeatTick = 1'b0;
      rcntNext   = '0;
      if ((REPEAT_CYCLES > 0) && !releaseHit &&
          ((state == HELD) || (state == RELEASE_CHK))) begin
         if (rcnt == REPEAT_LAST) begin
            repeatTick = 1'b1;
         end else begin
            rcntNext = rcnt + CNT_ONE;
         end
      end
   end

   assign eventHit = pressHit | repeatTick;

   // Output decode: the debounced level is high in both held-side states.
   always_comb begin
      debounce = (state == HELD) || (state == RELEASE_CHK);
   end

   // Event flags: a new event always sets pending, even when acknowledged on
   // the same edge; overrun only latches when nobody is acknowledging.
   always_ff @(posedge clock) begin
      if (reset) begin
         press_pulse <= 1'b0;
         pending     <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         press_pulse <= eventHit;
         if (eventHit) begin
            pending <= 1'b1;
            if (pending && !acknowledge) begin
               overrun <= 1'b1;
            end
         end else if (acknowledge) begin
            pending <= 1'b0;
            overrun <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/debounce_array.sv
// ---------------------------------------------------------------------------
// debounce_array
// Parametrised multi-channel push-button conditioner; one independent
// debounce_channel per button.
// Ports (all CHANNELS wide except clock/reset):
//   clock, reset     : single clock, synchronous active-high reset
//   buttonNotPressed : raw active-low buttons
//   acknowledge      : per-channel clear of pending/overrun
//   debounce         : debounced pressed levels
//   press_pulse      : per-channel press/repeat strobes
//   pending          : sticky event flags
//   overrun          : sticky overrun flags
// ---------------------------------------------------------------------------
module debounce_array
   import debounce_pkg::*;
#(
   parameter int CHANNELS      = 4,
   parameter int STABLE_CYCLES = 50000,
   parameter int REPEAT_CYCLES = 0
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [CHANNELS-1:0] buttonNotPressed,
   input  logic [CHANNELS-1:0] acknowledge,
   output logic [CHANNELS-1:0] debounce,
   output logic [CHANNELS-1:0] press_pulse,
   output logic [CHANNELS-1:0] pending,
   output logic [CHANNELS-1:0] overrun
);

   // Both counters share one width, large enough for the longer period.
   localparam int CNT_W = $clog2(maxInt(STABLE_CYCLES, REPEAT_CYCLES) + 1);

   for (genvar g = 0; g < CHANNELS; g++) begin : gChannel
      debounce_channel #(
         .STABLE_CYCLES (STABLE_CYCLES),
         .REPEAT_CYCLES (REPEAT_CYCLES),
         .CNT_W         (CNT_W)
      ) uChannel (
         .clock            (clock),
         .reset            (reset),
         .buttonNotPressed (buttonNotPressed[g]),
         .acknowledge      (acknowledge[g]),
         .debounce         (debounce[g]),
         .press_pulse      (press_pulse[g]),
         .pending          (pending[g]),
         .overrun          (overrun[g])
      );
   end

endmodule

// File: tb/tb_debounce_array.sv
// ---------------------------------------------------------------------------
// tb_debounce_array
// Directed bench for debounce_array (4 channels, 4-cycle debounce, 10-cycle
// repeat). A run-length reference model tracks every output each cycle and
// hand-computed expectations pin the key timing points.
// ---------------------------------------------------------------------------
module tb_debounce_array;

   localparam int CH = 4;
   localparam int ST = 4;
   localparam int RP = 10;

   logic          clock = 1'b0;
   logic          reset;
   logic [CH-1:0] buttonNotPressed;
   logic [CH-1:0] acknowledge;
   logic [CH-1:0] debounce;
   logic [CH-1:0] press_pulse;
   logic [CH-1:0] pending;
   logic [CH-1:0] overrun;

   int errors = 0;
   int checks = 0;

   logic          checkEn = 1'b0;
   logic [CH-1:0] mS1, mS2, mDeb, mPulse, mPend, mOvr;
   int            runLen [CH];
   int            ticks  [CH];
   logic [63:0]   pulseMask;
   logic [63:0]   expMask;

   debounce_array #(
      .CHANNELS      (CH),
      .STABLE_CYCLES (ST),
      .REPEAT_CYCLES (RP)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .buttonNotPressed (buttonNotPressed),
      .acknowledge      (acknowledge),
      .debounce         (debounce),
      .press_pulse      (press_pulse),
      .pending          (pending),
      .overrun          (overrun)
   );

   always #5 clock = ~clock;

   // Drive all inputs at once from the stimulus process.
   task automatic applyStimulus(input logic [CH-1:0] rawN, input logic [CH-1:0] ack,
                                input logic rst);
      buttonNotPressed = rawN;
      acknowledge      = ack;
      reset            = rst;
   endtask

   task automatic checkOutput(input string name, input logic [CH-1:0] actual,
                              input logic [CH-1:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
      end
   endtask

   // Leaves the caller at the falling edge after n rising edges.
   task automatic waitEdges(input int n);
      repeat (n) @(posedge clock);
      @(negedge clock);
   endtask

   // Reference model: the debounced level flips once the synchronised input
   // has disagreed with it on ST consecutive edges; while pressed, an event
   // fires every RP edges after the previous one.
   always @(posedge clock) begin
      logic syncNow;
      logic wasHeld;
      logic flipped;
      logic ev;
      if (reset) begin
         mS1 = '0; mS2 = '0; mDeb = '0; mPulse = '0; mPend = '0; mOvr = '0;
         for (int i = 0; i < CH; i++) begin
            runLen[i] = 0;
            ticks[i]  = 0;
         end
         checkEn = 1'b1;
      end else begin
         for (int i = 0; i < CH; i++) begin
            syncNow = mS2[i];
            mS2[i]  = mS1[i];
            mS1[i]  = ~buttonNotPressed[i];
            wasHeld = mDeb[i];
            flipped = 1'b0;
            ev      = 1'b0;
            if (syncNow != mDeb[i]) runLen[i]++;
            else runLen[i] = 0;
            if (runLen[i] == ST) begin
               mDeb[i]   = syncNow;
               runLen[i] = 0;
               flipped   = 1'b1;
               if (syncNow) ev = 1'b1;
            end
            if (wasHeld && !flipped) begin
               ticks[i]++;
               if (ticks[i] == RP) begin
                  ev       = 1'b1;
                  ticks[i] = 0;
               end
            end else begin
               ticks[i] = 0;
            end
            mPulse[i] = ev;
            if (ev) begin
               if (mPend[i] && !acknowledge[i]) mOvr[i] = 1'b1;
               mPend[i] = 1'b1;
            end else if (acknowledge[i]) begin
               mPend[i] = 1'b0;
               mOvr[i]  = 1'b0;
            end
         end
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clock) begin
      if (checkEn) begin
         checkOutput("model debounce", debounce, mDeb);
         checkOutput("model press_pulse", press_pulse, mPulse);
         checkOutput("model pending", pending, mPend);
         checkOutput("model overrun", overrun, mOvr);
      end
   end

   initial begin
      applyStimulus(4'hF, 4'h0, 1'b1);
      waitEdges(2);
      checkOutput("reset debounce", debounce, 4'b0000);
      checkOutput("reset press_pulse", press_pulse, 4'b0000);
      checkOutput("reset pending", pending, 4'b0000);
      checkOutput("reset overrun", overrun, 4'b0000);
      applyStimulus(4'hF, 4'h0, 1'b0);
      waitEdges(3);

      // Clean press on ch0
      applyStimulus(4'b1110, 4'h0, 1'b0);
      waitEdges(5);
      checkOutput("press edge5 debounce", debounce, 4'b0000);
      checkOutput("press edge5 pulse", press_pulse, 4'b0000);
      waitEdges(1);
      checkOutput("press edge6 debounce", debounce, 4'b0001);
      checkOutput("press edge6 pulse", press_pulse, 4'b0001);
      checkOutput("press edge6 pending", pending, 4'b0001);
      waitEdges(1);
      checkOutput("press edge7 pulse", press_pulse, 4'b0000);
      checkOutput("press edge7 pending", pending, 4'b0001);
      applyStimulus(4'hF, 4'h0, 1'b0);
      waitEdges(8);
      checkOutput("release ch0 debounce", debounce, 4'b0000);
      checkOutput("release keeps pending", pending, 4'b0001);
      applyStimulus(4'hF, 4'b0001, 1'b0);
      waitEdges(1);
      checkOutput("ack ch0 pending", pending, 4'b0000);
      applyStimulus(4'hF, 4'h0, 1'b0);
      waitEdges(2);

      // Glitch rejection on ch1
      applyStimulus(4'b1101, 4'h0, 1'b0);
      waitEdges(3);
      applyStimulus(4'hF, 4'h0, 1'b0);
      waitEdges(10);
      checkOutput("glitch debounce", debounce, 4'b0000);
      checkOutput("glitch pending", pending, 4'b0000);
      applyStimulus(4'b1101, 4'h0, 1'b0);
      waitEdges(6);
      checkOutput("ch1 press debounce", debounce, 4'b0010);
      applyStimulus(4'hF, 4'h0, 1'b0);
      waitEdges(2);
      applyStimulus(4'b1101, 4'h0, 1'b0);
      waitEdges(6);
      checkOutput("release bounce debounce", debounce, 4'b0010);
      applyStimulus(4'hF, 4'h0, 1'b0);
      waitEdges(8);
      checkOutput("ch1 release debounce", debounce, 4'b0000);
      applyStimulus(4'hF, 4'hF, 1'b0);
      waitEdges(1);
      applyStimulus(4'hF, 4'h0, 1'b0);
      waitEdges(2);
      checkOutput("ack all pending", pending, 4'b0000);
      checkOutput("ack all overrun", overrun, 4'b0000);

      // Overrun and acknowledge on ch2
      applyStimulus(4'b1011, 4'h0, 1'b0);
      waitEdges(6);
      checkOutput("ch2 first pulse", press_pulse, 4'b0100);
      checkOutput("ch2 first overrun", overrun, 4'b0000);
      waitEdges(1);
      applyStimulus(4'hF, 4'h0, 1'b0);
      waitEdges(8);
      applyStimulus(4'b1011, 4'h0, 1'b0);
      waitEdges(6);
      checkOutput("ch2 second pulse", press_pulse, 4'b0100);
      checkOutput("ch2 second overrun", overrun, 4'b0100);
      checkOutput("ch2 second pending", pending, 4'b0100);
      waitEdges(1);
      applyStimulus(4'hF, 4'b0100, 1'b0);
      waitEdges(1);
      checkOutput("ch2 ack pending", pending, 4'b0000);
      checkOutput("ch2 ack overrun", overrun, 4'b0000);
      applyStimulus(4'hF, 4'h0, 1'b0);
      waitEdges(8);
      applyStimulus(4'b1011, 4'h0, 1'b0);
      waitEdges(5);
      applyStimulus(4'b1011, 4'b0100, 1'b0);
      waitEdges(1);
      checkOutput("ack with event pulse", press_pulse, 4'b0100);
      checkOutput("ack with event pending", pending, 4'b0100);
      applyStimulus(4'hF, 4'h0, 1'b0);
      waitEdges(1);
      checkOutput("set wins pending", pending, 4'b0100);
      waitEdges(8);
      applyStimulus(4'hF, 4'b0100, 1'b0);
      waitEdges(1);
      applyStimulus(4'hF, 4'h0, 1'b0);
      waitEdges(2);

      // Auto-repeat on ch3: held for 40 edges, released at edge 41
      pulseMask = '0;
      expMask   = '0;
      expMask[6]  = 1'b1;
      expMask[16] = 1'b1;
      expMask[26] = 1'b1;
      expMask[36] = 1'b1;
      applyStimulus(4'b0111, 4'h0, 1'b0);
      for (int e = 1; e <= 60; e++) begin
         if (e == 41) applyStimulus(4'hF, 4'h0, 1'b0);
         waitEdges(1);
         if (press_pulse[3]) pulseMask[e] = 1'b1;
         if (e == 45) checkOutput("repeat debounce edge45", debounce, 4'b1000);
         if (e == 46) checkOutput("repeat debounce edge46", debounce, 4'b0000);
      end
      checks++;
      if (pulseMask !== expMask) begin
         errors++;
         $display("[TB] FAIL repeat pulse edges: got %h expected %h", pulseMask, expMask);
      end
      applyStimulus(4'hF, 4'hF, 1'b0);
      waitEdges(1);
      applyStimulus(4'hF, 4'h0, 1'b0);
      waitEdges(2);

      // Reset while ch0 is held with pending set
      applyStimulus(4'b1110, 4'h0, 1'b0);
      waitEdges(7);
      checkOutput("pre-reset pending", pending, 4'b0001);
      applyStimulus(4'b1110, 4'h0, 1'b1);
      waitEdges(1);
      checkOutput("mid reset debounce", debounce, 4'b0000);
      checkOutput("mid reset pulse", press_pulse, 4'b0000);
      checkOutput("mid reset pending", pending, 4'b0000);
      checkOutput("mid reset overrun", overrun, 4'b0000);
      applyStimulus(4'b1110, 4'h0, 1'b0);
      waitEdges(5);
      checkOutput("post reset edge5 pulse", press_pulse, 4'b0000);
      waitEdges(1);
      checkOutput("post reset edge6 pulse", press_pulse, 4'b0001);
      checkOutput("post reset edge6 debounce", debounce, 4'b0001);
      applyStimulus(4'hF, 4'h0, 1'b0);
      waitEdges(8);
      applyStimulus(4'hF, 4'hF, 1'b0);
      waitEdges(1);
      applyStimulus(4'hF, 4'h0, 1'b0);
      waitEdges(2);

      // Simultaneous press on all channels, partial acknowledge
      applyStimulus(4'b0000, 4'h0, 1'b0);
      waitEdges(6);
      checkOutput("all pulse", press_pulse, 4'b1111);
      checkOutput("all pending", pending, 4'b1111);
      checkOutput("all overrun", overrun, 4'b0000);
      applyStimulus(4'b0000, 4'b0101, 1'b0);
      waitEdges(1);
      checkOutput("partial ack pending", pending, 4'b1010);
      checkOutput("partial ack pulse", press_pulse, 4'b0000);
      applyStimulus(4'hF, 4'h0, 1'b0);
      waitEdges(10);
      checkOutput("all released", debounce, 4'b0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
